// File: rtl/vga_ctrl_pkg.sv
// Shared constants and types for the rectangle-layer colour compositor.
// Screen geometry defaults, host field codes, colour widths and commit states.
package vga_ctrl_pkg;

    localparam int H_VIS_DEF = 640;
    localparam int V_VIS_DEF = 480;

    localparam int R_W   = 3;
    localparam int G_W   = 3;
    localparam int B_W   = 2;
    localparam int COL_W = R_W + G_W + B_W;

    localparam int PIPE_LAT = 2;

    typedef enum logic [2:0] {
        FLD_X0     = 3'd0,
        FLD_X1     = 3'd1,
        FLD_Y0     = 3'd2,
        FLD_Y1     = 3'd3,
        FLD_COLOUR = 3'd4,
        FLD_ENABLE = 3'd5,
        FLD_RSVD6  = 3'd6,
        FLD_RSVD7  = 3'd7
    } wr_field_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COPY    = 2'd2
    } commit_state_e;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/rect_layer_ctrl_if.sv
// Host-side layer write port and commit handshake.
// The host is the master; the compositor is the slave.
interface rect_layer_ctrl_if #(
    parameter int COORD_W = 10
) ();

    logic               WR_VALID;
    logic               WR_READY;
    logic [2:0]         WR_LAYER;
    logic [2:0]         WR_FIELD;
    logic [COORD_W-1:0] WR_DATA;
    logic               COMMIT;
    logic               COMMIT_PENDING;

    modport master (
        output WR_VALID, WR_LAYER, WR_FIELD, WR_DATA, COMMIT,
        input  WR_READY, COMMIT_PENDING
    );

    modport slave (
        input  WR_VALID, WR_LAYER, WR_FIELD, WR_DATA, COMMIT,
        output WR_READY, COMMIT_PENDING
    );

endinterface

// File: rtl/rect_layer_regs.sv
// One rectangle layer: shadow/active banks, field decode and stage-1 hit.
// The active bank only moves on the copy strobe, so a frame never sees half a rectangle.
module rect_layer_regs
    import vga_ctrl_pkg::*;
#(
    parameter int COORD_W = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               wr_en_i,
    input  wr_field_e          wr_field_i,
    input  logic [COORD_W-1:0] wr_data_i,
    input  logic               copy_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic               hit_o,
    output logic [COL_W-1:0]   colour_o
);

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] y1;
        logic [COL_W-1:0]   col;
        logic               en;
    } layer_t;

    layer_t shadow_q, shadow_d;
    layer_t active_q, active_d;
    logic   hit_q, hit_d;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en_i) begin
            case (wr_field_i)
                FLD_X0:     shadow_d.x0  = wr_data_i;
                FLD_X1:     shadow_d.x1  = wr_data_i;
                FLD_Y0:     shadow_d.y0  = wr_data_i;
                FLD_Y1:     shadow_d.y1  = wr_data_i;
                FLD_COLOUR: shadow_d.col = wr_data_i[COL_W-1:0];
                FLD_ENABLE: shadow_d.en  = wr_data_i[0];
                default:    ;
            endcase
        end
    end

    assign active_d = copy_i ? shadow_q : active_q;

    // Exclusive upper bounds make x1<=x0 or y1<=y0 an empty rectangle.
    assign hit_d = active_q.en
                && (x_i >= active_q.x0) && (x_i < active_q.x1)
                && (y_i >= active_q.y0) && (y_i < active_q.y1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
            active_q <= '0;
            hit_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            hit_q    <= hit_d;
        end
    end

    assign hit_o    = hit_q;
    assign colour_o = active_q.col;

endmodule

// File: rtl/rect_layer_ctrl.sv
// Frame-synchronous rectangle compositor: N layers, fixed priority, 2-cycle pixel path.
// Optional RECT_LAYER_COLLISION_EN adds per-frame layer collision flags on COLLIDE.
module rect_layer_ctrl
    import vga_ctrl_pkg::*;
#(
    parameter int               N_LAYERS  = 4,
    parameter int               COORD_W   = 10,
    parameter int               H_VIS     = H_VIS_DEF,
    parameter int               V_VIS     = V_VIS_DEF,
    parameter logic [COL_W-1:0] BG_COLOUR = 8'h00
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [COORD_W-1:0]  X,
    input  logic [COORD_W-1:0]  Y,
    input  logic                HS_IN,
    input  logic                VS_IN,
    rect_layer_ctrl_if.slave    wr,
    output logic                HS,
    output logic                VS,
    output logic [R_W-1:0]      RED,
    output logic [G_W-1:0]      GREEN,
    output logic [B_W-1:0]      BLUE,
    output logic [3:0]          HIT_LAYER
`ifdef RECT_LAYER_COLLISION_EN
    ,
    output logic [N_LAYERS-1:0] COLLIDE
`endif
);

    localparam logic [COORD_W-1:0] H_VIS_C = COORD_W'(H_VIS);
    localparam logic [COORD_W-1:0] V_VIS_C = COORD_W'(V_VIS);

    commit_state_e state_q, state_d;
    logic          at_vblank_q;
    logic          boundary;
    logic          copy;
    logic          wr_accept;

    // Frame boundary is the first cycle of vertical blank.
    assign boundary  = (Y == V_VIS_C) && !at_vblank_q;
    assign wr_accept = wr.WR_VALID && wr.WR_READY;

    always_comb begin
        state_d           = state_q;
        copy              = 1'b0;
        wr.WR_READY       = 1'b1;
        wr.COMMIT_PENDING = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (wr.COMMIT) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                wr.COMMIT_PENDING = 1'b1;
                if (boundary) state_d = ST_COPY;
            end
            ST_COPY: begin
                copy              = 1'b1;
                wr.WR_READY       = 1'b0;
                wr.COMMIT_PENDING = 1'b1;
                state_d = wr.COMMIT ? ST_PENDING : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic [N_LAYERS-1:0] hit_vec;
    logic [COL_W-1:0]    layer_col [N_LAYERS];

    for (genvar i = 0; i < N_LAYERS; i++) begin : g_layer
        rect_layer_regs #(
            .COORD_W (COORD_W)
        ) u_regs (
            .clk_i      (CLK),
            .rst_ni     (RST_N),
            .wr_en_i    (wr_accept && (wr.WR_LAYER == 3'(i))),
            .wr_field_i (wr_field_e'(wr.WR_FIELD)),
            .wr_data_i  (wr.WR_DATA),
            .copy_i     (copy),
            .x_i        (X),
            .y_i        (Y),
            .hit_o      (hit_vec[i]),
            .colour_o   (layer_col[i])
        );
    end

    logic                vis_q;
    logic [PIPE_LAT-1:0] hs_pipe_q;
    logic [PIPE_LAT-1:0] vs_pipe_q;

    logic             win_found;
    logic [2:0]       win_idx;
    logic [COL_W-1:0] win_col;
    rgb_t             pix_q, pix_d;
    logic [3:0]       hit_layer_q, hit_layer_d;

    // Walk from the top index down so the lowest set hit is what remains.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_col   = '0;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                win_found = 1'b1;
                win_idx   = 3'(i);
                win_col   = layer_col[i];
            end
        end
        pix_d       = '0;
        hit_layer_d = '0;
        if (vis_q) begin
            if (win_found) begin
                pix_d       = rgb_t'(win_col);
                hit_layer_d = {1'b1, win_idx};
            end else begin
                pix_d = rgb_t'(BG_COLOUR);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            at_vblank_q <= 1'b0;
            vis_q       <= 1'b0;
            hs_pipe_q   <= '1;
            vs_pipe_q   <= '1;
            pix_q       <= '0;
            hit_layer_q <= '0;
        end else begin
            state_q     <= state_d;
            at_vblank_q <= (Y == V_VIS_C);
            vis_q       <= (X < H_VIS_C) && (Y < V_VIS_C);
            hs_pipe_q   <= {hs_pipe_q[PIPE_LAT-2:0], HS_IN};
            vs_pipe_q   <= {vs_pipe_q[PIPE_LAT-2:0], VS_IN};
            pix_q       <= pix_d;
            hit_layer_q <= hit_layer_d;
        end
    end

    assign HS        = hs_pipe_q[PIPE_LAT-1];
    assign VS        = vs_pipe_q[PIPE_LAT-1];
    assign RED       = pix_q.r;
    assign GREEN     = pix_q.g;
    assign BLUE      = pix_q.b;
    assign HIT_LAYER = hit_layer_q;

`ifdef RECT_LAYER_COLLISION_EN
    logic [N_LAYERS-1:0] coll_flags_q;
    logic [N_LAYERS-1:0] collide_q;
    logic [N_LAYERS-1:0] coll_new;

    assign coll_new = (vis_q && ($countones(hit_vec) > 1)) ? hit_vec : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            coll_flags_q <= '0;
            collide_q    <= '0;
        end else if (boundary) begin
            collide_q    <= coll_flags_q | coll_new;
            coll_flags_q <= '0;
        end else begin
            coll_flags_q <= coll_flags_q | coll_new;
        end
    end

    assign COLLIDE = collide_q;
`endif

endmodule
